// File: rtl/alu_seq_unit.sv
// EX-stage ALU: decodes aluOp/funct into a 4-bit code and executes one op at a time.
// Shifts run one bit per cycle; define ALU_SEQ_MULT_EN to add an iterative shift-add multiply.
module alu_seq_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clock,
   input  logic               resetN,
   input  logic               inValid,
   output logic               inReady,
   input  logic [1:0]         aluOp,
   input  logic [5:0]         funct,
   input  logic [WIDTH-1:0]   opA,
   input  logic [WIDTH-1:0]   opB,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               outValid,
   input  logic               outReady,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic [3:0]         aluCtl,
   output logic               illegal
);

   localparam int CNT_W = SHAMT_W + 1;

   localparam logic [3:0] CTL_AND = 4'b0000;
   localparam logic [3:0] CTL_OR  = 4'b0001;
   localparam logic [3:0] CTL_ADD = 4'b0010;
   localparam logic [3:0] CTL_XOR = 4'b0011;
   localparam logic [3:0] CTL_SUB = 4'b0110;
   localparam logic [3:0] CTL_SLT = 4'b0111;
   localparam logic [3:0] CTL_SLL = 4'b1000;
   localparam logic [3:0] CTL_SRL = 4'b1001;
   localparam logic [3:0] CTL_SRA = 4'b1010;
   localparam logic [3:0] CTL_NOR = 4'b1100;
   localparam logic [3:0] CTL_MUL = 4'b1110;
   localparam logic [3:0] CTL_BAD = 4'b1111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_SHIFT,
`ifdef ALU_SEQ_MULT_EN
      S_MUL,
`endif
      S_DONE
   } state_t;

   state_t             r_state, w_next;
   logic [WIDTH-1:0]   r_a, r_b, r_result;
   logic [SHAMT_W-1:0] r_shamt;
   logic [CNT_W-1:0]   r_cnt;
   logic [3:0]         r_ctl;
   logic               r_ill;

   logic [3:0]         w_ctl;
   logic               w_ill;
   logic               w_is_shift;
   logic [WIDTH-1:0]   w_simple, w_shift1;

   always_comb begin
      w_ctl = CTL_ADD;
      w_ill = 1'b0;
      case (aluOp)
         2'b00: w_ctl = CTL_ADD;
         2'b01: w_ctl = CTL_SUB;
         2'b11: w_ctl = CTL_SLT;
         default: begin
            case (funct)
               6'b100000: w_ctl = CTL_ADD;
               6'b100010: w_ctl = CTL_SUB;
               6'b100100: w_ctl = CTL_AND;
               6'b100101: w_ctl = CTL_OR;
               6'b100110: w_ctl = CTL_XOR;
               6'b100111: w_ctl = CTL_NOR;
               6'b101010: w_ctl = CTL_SLT;
               6'b000000: w_ctl = CTL_SLL;
               6'b000010: w_ctl = CTL_SRL;
               6'b000011: w_ctl = CTL_SRA;
`ifdef ALU_SEQ_MULT_EN
               6'b011000: w_ctl = CTL_MUL;
`endif
               default: begin
                  w_ctl = CTL_BAD;
                  w_ill = 1'b1;
               end
            endcase
         end
      endcase
   end

   assign w_is_shift = (r_ctl == CTL_SLL) || (r_ctl == CTL_SRL) || (r_ctl == CTL_SRA);

   // Shift ops land here only with shamt=0, where the result is opB unchanged.
   always_comb begin
      w_simple = '0;
      case (r_ctl)
         CTL_ADD: w_simple = r_a + r_b;
         CTL_SUB: w_simple = r_a - r_b;
         CTL_AND: w_simple = r_a & r_b;
         CTL_OR:  w_simple = r_a | r_b;
         CTL_XOR: w_simple = r_a ^ r_b;
         CTL_NOR: w_simple = ~(r_a | r_b);
         CTL_SLT: w_simple = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
         CTL_SLL, CTL_SRL, CTL_SRA: w_simple = r_b;
         default: w_simple = '0;
      endcase
   end

   always_comb begin
      w_shift1 = r_result;
      case (r_ctl)
         CTL_SLL: w_shift1 = {r_result[WIDTH-2:0], 1'b0};
         CTL_SRL: w_shift1 = {1'b0, r_result[WIDTH-1:1]};
         CTL_SRA: w_shift1 = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
         default: w_shift1 = r_result;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (inValid) w_next = S_EXEC;
         S_EXEC: begin
            w_next = S_DONE;
            if (w_is_shift && (r_shamt != '0)) w_next = S_SHIFT;
`ifdef ALU_SEQ_MULT_EN
            if (r_ctl == CTL_MUL) w_next = S_MUL;
`endif
         end
         S_SHIFT: if (r_cnt == CNT_W'(1)) w_next = S_DONE;
`ifdef ALU_SEQ_MULT_EN
         S_MUL:   if (r_cnt == CNT_W'(1)) w_next = S_DONE;
`endif
         S_DONE:  if (outReady) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_a      <= '0;
         r_b      <= '0;
         r_shamt  <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_ctl    <= '0;
         r_ill    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (inValid) begin
               r_a     <= opA;
               r_b     <= opB;
               r_shamt <= shamt;
               r_ctl   <= w_ctl;
               r_ill   <= w_ill;
            end
            S_EXEC: begin
               if (w_is_shift && (r_shamt != '0)) begin
                  r_result <= r_b;
                  r_cnt    <= {1'b0, r_shamt};
               end
`ifdef ALU_SEQ_MULT_EN
               else if (r_ctl == CTL_MUL) begin
                  r_result <= '0;
                  r_cnt    <= CNT_W'(WIDTH);
               end
`endif
               else r_result <= w_simple;
            end
            S_SHIFT: begin
               r_result <= w_shift1;
               r_cnt    <= r_cnt - CNT_W'(1);
            end
`ifdef ALU_SEQ_MULT_EN
            // result doubles as the accumulator; opA/opB are consumed as shift registers
            S_MUL: begin
               if (r_b[0]) r_result <= r_result + r_a;
               r_a   <= {r_a[WIDTH-2:0], 1'b0};
               r_b   <= {1'b0, r_b[WIDTH-1:1]};
               r_cnt <= r_cnt - CNT_W'(1);
            end
`endif
            default: ;
         endcase
      end
   end

   assign inReady  = (r_state == S_IDLE);
   assign outValid = (r_state == S_DONE);
   assign result   = r_result;
   assign zero     = (r_result == '0);
   assign aluCtl   = r_ctl;
   assign illegal  = r_ill;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: driver pushes model results, monitor checks on outValid.
// Honours ALU_SEQ_MULT_EN the same way as the design.
module tb_alu_seq_unit;

   logic        clock = 1'b0;
   logic        resetN = 1'b0;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [1:0]  aluOp = '0;
   logic [5:0]  funct = '0;
   logic [31:0] opA = '0, opB = '0;
   logic [4:0]  shamt = '0;
   logic        outValid;
   logic        outReady = 1'b0;
   logic [31:0] result;
   logic        zero;
   logic [3:0]  aluCtl;
   logic        illegal;

   alu_seq_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
      .aluOp(aluOp), .funct(funct), .opA(opA), .opB(opB), .shamt(shamt),
      .outValid(outValid), .outReady(outReady), .result(result), .zero(zero),
      .aluCtl(aluCtl), .illegal(illegal)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  ctl;
      logic        ill;
      int          lat;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0, n_err = 0;
   int   cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: decode table plus plain arithmetic on whole words.
   function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                  input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      exp_t e;
      e.res = '0; e.ctl = 4'b0010; e.ill = 1'b0; e.lat = 1; e.acc = 0;
      case (op)
         2'b00: begin e.ctl = 4'b0010; e.res = a + b; end
         2'b01: begin e.ctl = 4'b0110; e.res = a - b; end
         2'b11: begin e.ctl = 4'b0111; e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
         default: case (f)
            6'h20: begin e.ctl = 4'b0010; e.res = a + b; end
            6'h22: begin e.ctl = 4'b0110; e.res = a - b; end
            6'h24: begin e.ctl = 4'b0000; e.res = a & b; end
            6'h25: begin e.ctl = 4'b0001; e.res = a | b; end
            6'h26: begin e.ctl = 4'b0011; e.res = a ^ b; end
            6'h27: begin e.ctl = 4'b1100; e.res = ~(a | b); end
            6'h2a: begin e.ctl = 4'b0111; e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            6'h00: begin e.ctl = 4'b1000; e.res = b << sh; e.lat = 1 + int'(sh); end
            6'h02: begin e.ctl = 4'b1001; e.res = b >> sh; e.lat = 1 + int'(sh); end
            6'h03: begin e.ctl = 4'b1010; e.res = $signed(b) >>> sh; e.lat = 1 + int'(sh); end
`ifdef ALU_SEQ_MULT_EN
            6'h18: begin e.ctl = 4'b1110; e.res = a * b; e.lat = 33; end
`endif
            default: begin e.ctl = 4'b1111; e.ill = 1'b1; e.res = '0; end
         endcase
      endcase
      return e;
   endfunction

   task automatic finish_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input bit push);
      int t = 0;
      exp_t e;
      while (!inReady) begin
         inValid = 1'b1; aluOp = 2'($urandom); funct = 6'($urandom);
         opA = $urandom; opB = $urandom; shamt = 5'($urandom);
         @(negedge clock);
         t++;
         if (t > 200) begin
            n_err++;
            $display("FAIL accept_timeout: inReady stayed 0 for %0d cycles", t);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $fatal(1);
         end
      end
      inValid = 1'b1; aluOp = op; funct = f; opA = a; opB = b; shamt = sh;
      @(posedge clock);
      #1;
      if (push) begin
         e = model(op, f, a, b, sh);
         e.acc = cyc;
         q.push_back(e);
      end
      // Junk offered while busy must be ignored.
      aluOp = 2'($urandom); funct = 6'($urandom); opA = $urandom; opB = $urandom;
      @(negedge clock);
   endtask

   task automatic drain();
      int t = 0;
      inValid = 1'b0;
      while ((q.size() != 0) && (t < 1000)) begin
         @(negedge clock);
         t++;
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      end
   endtask

   // Monitor: compares the head of the scoreboard whenever outValid is seen.
   bit first = 1'b1, pop_pending = 1'b0;
   int hold = 0, n_items = 0;
   always @(negedge clock) begin
      if (resetN) begin
         if (pop_pending) begin
            chk("idle_after_pop.inReady", 32'(inReady), 32'd1);
            pop_pending = 1'b0;
         end
         if (outValid) begin
            if (q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_out: result %h with empty scoreboard, expected none", result);
            end else begin
               if (first) begin
                  chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                  hold = (n_items == 3) ? 5 : int'($urandom_range(0, 3));
                  n_items++;
                  first = 1'b0;
               end
               chk("result", result, q[0].res);
               chk("zero", 32'(zero), (q[0].res == 0) ? 32'd1 : 32'd0);
               chk("aluCtl", 32'(aluCtl), 32'(q[0].ctl));
               chk("illegal", 32'(illegal), 32'(q[0].ill));
               chk("inReady_busy", 32'(inReady), 32'd0);
               if (hold > 0) begin
                  outReady = 1'b0;
                  hold--;
               end else begin
                  outReady = 1'b1;
                  void'(q.pop_front());
                  first = 1'b1;
                  pop_pending = 1'b1;
               end
            end
         end else begin
            outReady = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      #400000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1);
   end

   logic [5:0] fl [0:11];
   initial begin
      fl[0] = 6'h20; fl[1] = 6'h22; fl[2]  = 6'h24; fl[3]  = 6'h25;
      fl[4] = 6'h26; fl[5] = 6'h27; fl[6]  = 6'h2a; fl[7]  = 6'h00;
      fl[8] = 6'h02; fl[9] = 6'h03; fl[10] = 6'h18; fl[11] = 6'h3f;

      repeat (3) @(negedge clock);
      chk("reset.result", result, 32'd0);
      chk("reset.zero", 32'(zero), 32'd1);
      chk("reset.aluCtl", 32'(aluCtl), 32'd0);
      chk("reset.illegal", 32'(illegal), 32'd0);
      chk("reset.inReady", 32'(inReady), 32'd1);
      chk("reset.outValid", 32'(outValid), 32'd0);
      resetN = 1'b1;
      @(negedge clock);

      issue(2'b10, 6'h20, 32'd5, 32'd7, 5'd0, 1'b1);
      issue(2'b01, 6'h3f, 32'h1234, 32'h1234, 5'd0, 1'b1);
      issue(2'b11, 6'h00, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
      issue(2'b10, 6'h03, 32'd0, 32'h8000_0000, 5'd4, 1'b1);
      issue(2'b10, 6'h03, 32'd0, 32'h8000_0000, 5'd0, 1'b1);
      issue(2'b10, 6'h18, 32'd3, 32'hFFFF_FFFE, 5'd0, 1'b1);
      issue(2'b10, 6'h00, 32'h1, 32'h0000_0001, 5'd31, 1'b1);
      issue(2'b10, 6'h2a, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0, 1'b1);

      for (int i = 0; i < 60; i++) begin
         logic [1:0] op;
         op = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
         issue(op, fl[$urandom_range(0, 11)], $urandom, $urandom, 5'($urandom), 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            inValid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clock);
         end
      end
      drain();

      // Abort a long shift with reset; nothing of it may surface.
      issue(2'b10, 6'h00, 32'd0, 32'h0000_00FF, 5'd20, 1'b0);
      inValid = 1'b0;
      repeat (5) @(negedge clock);
      resetN = 1'b0;
      #1;
      chk("abort.outValid", 32'(outValid), 32'd0);
      chk("abort.result", result, 32'd0);
      chk("abort.aluCtl", 32'(aluCtl), 32'd0);
      chk("abort.inReady", 32'(inReady), 32'd1);
      @(negedge clock);
      resetN = 1'b1;
      @(negedge clock);
      chk("post_reset.inReady", 32'(inReady), 32'd1);
      issue(2'b00, 6'h00, 32'd100, 32'd23, 5'd0, 1'b1);
      drain();

      finish_run();
   end

endmodule
